// File: rtl/gmem_round_robin_scheduler.sv
// Registered round-robin scheduler for the shared global-memory/device port.
// Define SCHED_LOCK_EN to honour per-core lock hints (bounded by MAX_HOLD).
module gmem_round_robin_scheduler #(
  parameter int NUM_REQ  = 16,
  parameter int MAX_HOLD = 8,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  request,
  input  logic [NUM_REQ-1:0]  lock,
  output logic [NUM_REQ-1:0]  grant_oh,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                grant_valid,
  output logic                hold_timeout
);

  logic [ID_WIDTH-1:0] r_last;
  logic [ID_WIDTH-1:0] r_grant_id;
  logic [NUM_REQ-1:0]  r_grant_oh;
  logic                r_grant_valid;
  logic                r_hold_timeout;

  logic [NUM_REQ-1:0]  w_above_last;
  logic                w_hi_found;
  logic [ID_WIDTH-1:0] w_hi_idx;
  logic                w_lo_found;
  logic [ID_WIDTH-1:0] w_lo_idx;
  logic                w_win_found;
  logic [ID_WIDTH-1:0] w_win_idx;
  logic                w_keep;
  logic                w_timeout;

  // Lowest requester above `last` wins; otherwise wrap to the lowest overall,
  // which leaves `last` itself as the final candidate.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_above_last = '0;
    w_hi_found   = 1'b0;
    w_hi_idx     = '0;
    w_lo_found   = 1'b0;
    w_lo_idx     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_above_last[i] = ID_WIDTH'(i) > r_last;
      if (request[i] && w_above_last[i]) begin
        w_hi_found = 1'b1;
        w_hi_idx   = ID_WIDTH'(i);
      end
      if (request[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = ID_WIDTH'(i);
      end
    end
  end

  assign w_win_found = w_lo_found;
  assign w_win_idx   = w_hi_found ? w_hi_idx : w_lo_idx;

`ifdef SCHED_LOCK_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic              w_locked;

  assign w_locked  = r_grant_valid && request[r_grant_id] && lock[r_grant_id];
  assign w_keep    = w_locked && (r_hold_cnt < HOLD_W'(MAX_HOLD));
  assign w_timeout = w_locked && (r_hold_cnt == HOLD_W'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (reset)       r_hold_cnt <= '0;
    else if (w_keep) r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
    else             r_hold_cnt <= '0;
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^lock;
  assign w_keep        = 1'b0;
  assign w_timeout     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_grant_oh     <= '0;
      r_grant_id     <= '0;
      r_grant_valid  <= 1'b0;
      r_hold_timeout <= 1'b0;
      r_last         <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      r_hold_timeout <= w_timeout;
      if (!w_keep) begin
        if (w_win_found) begin
          r_grant_oh    <= NUM_REQ'(1) << w_win_idx;
          r_grant_id    <= w_win_idx;
          r_grant_valid <= 1'b1;
          r_last        <= w_win_idx;
        end else begin
          r_grant_oh    <= '0;
          r_grant_valid <= 1'b0;
        end
      end
    end
  end

  assign grant_oh     = r_grant_oh;
  assign grant_id     = r_grant_id;
  assign grant_valid  = r_grant_valid;
  assign hold_timeout = r_hold_timeout;

endmodule
